// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin scheduler sharing one shift-add multiplier across four channels
// Each job is granted, multiplied in WIDTH iterations, then steered into its channel's result slot.
module mult_rr_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  output logic [3:0]           gnt,
  output logic [3:0]           done,
  output logic [8*WIDTH-1:0]   res_out,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t               state;
  logic [1:0]           ptr;
  logic [1:0]           chan;
  logic [1:0]           win;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplr;

  // Scan downward so the closest set bit at or after ptr is the last assignment.
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end
  end

  assign acc_next = mplr[0] ? acc + mcand : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      chan    <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      gnt     <= '0;
      done    <= '0;
      res_out <= '0;
      busy    <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            chan  <= win;
            mcand <= {{WIDTH{1'b0}}, a_in[win*WIDTH +: WIDTH]};
            mplr  <= b_in[win*WIDTH +: WIDTH];
            acc   <= '0;
            cnt   <= '0;
            gnt   <= 4'b0001 << win;
            busy  <= 1'b1;
            state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            res_out[chan*2*WIDTH +: 2*WIDTH] <= acc_next;
            done  <= 4'b0001 << chan;
            ptr   <= chan + 2'd1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - randomized bench for mult_rr_scheduler against a job-timeline model
// The model schedules each job as (grant edge, product, done edge) and derives outputs from that.
module tb_mult_rr_scheduler;

  localparam int W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*W-1:0]     a_in;
  logic [4*W-1:0]     b_in;
  logic [3:0]         gnt;
  logic [3:0]         done;
  logic [8*W-1:0]     res_out;
  logic               busy;

  mult_rr_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .res_out(res_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one job at a time, timed by edge count since its grant.
  logic [3:0]     exp_gnt = '0;
  logic [3:0]     exp_done = '0;
  logic           exp_busy = 1'b0;
  logic [8*W-1:0] exp_res = '0;
  int             m_ptr = 0;
  int             m_ch = 0;
  int             m_gt = 0;
  int             mt = 0;
  bit             m_active = 1'b0;
  logic [2*W-1:0] m_prod = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_ptr    = 0;
      exp_gnt  = '0;
      exp_done = '0;
      exp_busy = 1'b0;
      exp_res  = '0;
    end else begin
      logic [2*W-1:0] ma, mb;
      bit found;
      mt++;
      exp_gnt  = '0;
      exp_done = '0;
      if (!m_active) begin
        exp_busy = 1'b0;
        if (req != 4'b0) begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            if (!found && req[(m_ptr + k) % 4]) begin
              m_ch  = (m_ptr + k) % 4;
              found = 1'b1;
            end
          end
          ma       = {{W{1'b0}}, a_in[m_ch*W +: W]};
          mb       = {{W{1'b0}}, b_in[m_ch*W +: W]};
          m_prod   = ma * mb;
          m_gt     = mt;
          m_active = 1'b1;
          exp_gnt  = 4'b0001 << m_ch;
          exp_busy = 1'b1;
        end
      end else if (mt - m_gt == W) begin
        exp_done = 4'b0001 << m_ch;
        exp_res[m_ch*2*W +: 2*W] = m_prod;
        m_ptr = (m_ch + 1) % 4;
      end else if (mt - m_gt == W + 1) begin
        m_active = 1'b0;
        exp_busy = 1'b0;
      end
    end
  end

  always @(posedge clk) cyc++;

  // Compare process plus event logging used by the directed checks.
  int         gq[$];
  int         gq_cyc[$];
  int         done_cnt[4] = '{0, 0, 0, 0};
  int         last_gnt_cyc[4] = '{0, 0, 0, 0};
  int         last_done_cyc[4] = '{0, 0, 0, 0};
  int         done_total = 0;
  int         busy_cnt = 0;
  logic [3:0] done_seen = '0;

  always @(negedge clk) begin
    chk("gnt", 64'(gnt), 64'(exp_gnt));
    chk("done", 64'(done), 64'(exp_done));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("res_out", res_out, exp_res);
    done_seen = done;
    if (busy) busy_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        gq.push_back(i);
        gq_cyc.push_back(cyc);
        last_gnt_cyc[i] = cyc;
      end
      if (done[i]) begin
        done_cnt[i]++;
        done_total++;
        last_done_cyc[i] = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_op(input int ch, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[ch*W +: W] = a;
    b_in[ch*W +: W] = b;
  endtask

  function automatic logic [2*W-1:0] slot(input int i);
    return res_out[i*2*W +: 2*W];
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    case ($urandom_range(3))
      0:       r = '0;
      1:       r = '1;
      default: r = W'($urandom);
    endcase
    return r;
  endfunction

  // Keeps requests up until their done pulse is observed, then drops them.
  task automatic serve(input int njobs);
    int target = done_total + njobs;
    int t = 0;
    while (done_total < target && t < 40 * njobs) begin
      step(1);
      req = req & ~done_seen;
      t++;
    end
    if (done_total < target) chk("serve_timeout", 64'(done_total), 64'(target));
  endtask

  task automatic wait_gnt(input int n);
    int t = 0;
    while (gq.size() < n && t < 200) begin
      step(1);
      t++;
    end
    if (gq.size() < n) chk("gnt_timeout", 64'(gq.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int dc;
    logic [3:0] req_v;
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    step(2);
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_res", res_out, 64'd0);
    rst_n = 1'b1;
    step(1);

    // Single request on channel 2.
    set_op(2, 8'd13, 8'd11);
    busy_cnt = 0;
    req = 4'b0100;
    serve(1);
    chk("t1_slot2", 64'(slot(2)), 64'd143);
    chk("t1_other", 64'({slot(0), slot(1), slot(3)}), 64'd0);
    chk("t1_latency", 64'(last_done_cyc[2] - last_gnt_cyc[2]), 64'd8);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd9);

    // Extreme operands on channel 1.
    set_op(1, 8'd255, 8'd255);
    req = 4'b0010;
    serve(1);
    chk("t2_max", 64'(slot(1)), 64'hFE01);
    chk("t2_lat_max", 64'(last_done_cyc[1] - last_gnt_cyc[1]), 64'd8);
    set_op(1, 8'd0, 8'd200);
    req = 4'b0010;
    serve(1);
    chk("t2_zero", 64'(slot(1)), 64'd0);
    chk("t2_lat_zero", 64'(last_done_cyc[1] - last_gnt_cyc[1]), 64'd8);
    chk("t2_slot2_kept", 64'(slot(2)), 64'd143);

    // All four at once from reset.
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, W'(i + 1), 8'd10);
    gq.delete();
    gq_cyc.delete();
    req = 4'b1111;
    serve(4);
    if (gq.size() < 4) chk("t3_grants", 64'(gq.size()), 64'd4);
    else begin
      for (int i = 0; i < 4; i++) chk("t3_order", 64'(gq[i]), 64'(i));
      for (int i = 1; i < 4; i++) chk("t3_spacing", 64'(gq_cyc[i] - gq_cyc[i-1]), 64'd10);
    end
    chk("t3_slots", res_out, {16'd40, 16'd30, 16'd20, 16'd10});

    // Fairness with two continuous requesters.
    gq.delete();
    gq_cyc.delete();
    req = 4'b1001;
    wait_gnt(4);
    req = '0;
    step(12);
    if (gq.size() >= 4) begin
      chk("t4_g0", 64'(gq[0]), 64'd0);
      chk("t4_g1", 64'(gq[1]), 64'd3);
      chk("t4_g2", 64'(gq[2]), 64'd0);
      chk("t4_g3", 64'(gq[3]), 64'd3);
    end

    // Operand change after capture is ignored.
    gq.delete();
    gq_cyc.delete();
    set_op(0, 8'd77, 8'd3);
    req = 4'b0001;
    wait_gnt(1);
    step(1);
    set_op(0, 8'd200, 8'd3);
    serve(1);
    chk("t5_captured", 64'(slot(0)), 64'd231);

    // Reset in the middle of a channel 2 job.
    gq.delete();
    gq_cyc.delete();
    set_op(2, 8'd9, 8'd9);
    set_op(3, 8'd5, 8'd6);
    req = 4'b0100;
    wait_gnt(1);
    step(3);
    req = 4'b1100;
    dc = done_cnt[2];
    rst_n = 1'b0;
    #1;
    chk("t6_abort_outputs", {res_out[62:0], busy}, 64'd0);
    chk("t6_abort_pulses", 64'({gnt, done}), 64'd0);
    step(2);
    rst_n = 1'b1;
    chk("t6_no_done", 64'(done_cnt[2]), 64'(dc));
    gq.delete();
    gq_cyc.delete();
    serve(2);
    if (gq.size() >= 2) begin
      chk("t6_first", 64'(gq[0]), 64'd2);
      chk("t6_second", 64'(gq[1]), 64'd3);
    end
    chk("t6_slot2", 64'(slot(2)), 64'd81);
    chk("t6_slot3", 64'(slot(3)), 64'd30);

    // Randomized traffic, operand churn and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step(1);
      req_v = req & ~done_seen;
      for (int i = 0; i < 4; i++) begin
        if (!req_v[i] && $urandom_range(3) == 0) begin
          req_v[i] = 1'b1;
          set_op(i, rnd_op(), rnd_op());
        end else if (req_v[i] && $urandom_range(31) == 0) begin
          req_v[i] = 1'b0;
        end
      end
      if ($urandom_range(7) == 0) set_op($urandom_range(3), rnd_op(), rnd_op());
      req = req_v;
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
    end
    req = '0;
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
Shares one iterative shift-add multiplier between four requesters (channels 0-3) using a round-robin arbiter.
- Captures the winning channel's operands and runs a fixed-latency multiply.
- Steers the product into that channel's dedicated result register and pulses that channel's done flag.
- Sits in the Multiplier subsystem as the sequencer and steering controller ahead of the 4-way result distribution.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; multiply takes WIDTH compute cycles.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  per-channel request; held high until matching done bit seen
a_in  input  4*WIDTH  multiplicands; channel i at bits [i*WIDTH +: WIDTH]
b_in  input  4*WIDTH  multipliers; same packing as a_in
gnt  output  4  one-hot, one-cycle pulse: operands of channel i captured
done  output  4  one-hot, one-cycle pulse: channel i result valid
res_out  output  8*WIDTH  per-channel product; channel i at bits [i*2*WIDTH +: 2*WIDTH]
busy  output  1  high in COMPUTE and DONE states

Behaviour:
- Reset (rst_n low, async): state=IDLE, ptr=0, cnt=0, gnt=0, done=0, res_out=0, busy=0, internal accumulator/operand regs=0.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit scanning ptr, ptr+1, ... mod 4 (winner w).
  - At the edge: latch a_in[w] and b_in[w], set acc=0, set cnt=0, set gnt[w]=1 for exactly the following cycle, go to COMPUTE.
- COMPUTE (WIDTH edges):
  - Each edge: if multiplier LSB=1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++.
  - Arithmetic is unsigned; acc is 2*WIDTH bits and cannot overflow.
  - On the edge where cnt reaches WIDTH: write the final acc into res_out slot w, set done[w]=1, go to DONE.
- DONE (one cycle):
  - done[w] is high for this cycle only.
  - ptr=(w+1) mod 4.
  - Next edge returns to IDLE unconditionally.
- Latency: done[w] is asserted exactly WIDTH cycles after the gnt[w] cycle. Back-to-back grants are spaced WIDTH+2 cycles apart.
- Result slots not being written hold their previous value; they are never zeroed except by reset. A slot holds its value until that channel is served again.
- Operand capture: a_in/b_in are sampled only at the grant edge. Later changes, and changes on non-granted channels, are ignored.
- req dropped by a waiting channel before it is granted: the request is simply not served. No error.
- req of the channel being served is ignored during COMPUTE/DONE. If that req is still high in the following IDLE, it is treated as a new request, and round-robin ordering gives other channels priority.
- Zero operands still take the full WIDTH cycles; latency is fixed.
- Simultaneous requests: exactly one grant. The ptr rotation bounds any channel's wait to 3 services.
- Reset mid-operation:
  - Immediate abort; all outputs return to reset values.
  - No done pulse for the aborted job.
  - The next job after reset release uses ptr=0.
- gnt and done are never both nonzero in the same cycle. At most one bit of each is set.

Test Plan:
1. Single request, WIDTH=8: req=0100, a2=13, b2=11 -> gnt=0100 for one cycle; done=0100 eight cycles later; res slot2=143; slots 0,1,3 = 0; busy high for 9 cycles.
2. Max operands: ch1 a=255, b=255 -> slot1=0xFE01. Then ch1 a=0, b=200 -> slot1=0 with identical latency.
3. All four request at the same time from reset, each with a=i+1 and b=10 -> grant order 0,1,2,3, grants 10 cycles apart; slots = 10, 20, 30, 40.
4. Fairness: ch0 and ch3 hold req continuously -> grants alternate 0,3,0,3. ch3 is never starved.
5. Operand stability: a0 changed 2 cycles after gnt[0] -> result reflects the captured value only.
6. rst_n pulsed low at cnt=4 during a ch2 job -> outputs zero immediately; no done; after release a pending req=1100 is served ch2 first, then ch3.
